// File: rtl/spi_packet_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_packet_rx_if
// Brief   : SPI pins plus committed-packet handshake and status bundle.
// Rev     : 1.0
// ============================================================================
interface spi_packet_rx_if #(
    parameter int PACKET_BYTES = 16
);
    logic                      cs_n;
    logic                      sck;
    logic                      sdi;
    logic [8*PACKET_BYTES-1:0] pkt_data;
    logic                      pkt_valid;
    logic                      pkt_ready;
    logic                      busy;
    logic                      err_header;
    logic                      err_short;
    logic                      err_overrun;
    logic                      err_checksum;
    logic [15:0]               pkt_count;
    logic [7:0]                err_count;

    modport master (
        output cs_n, sck, sdi, pkt_ready,
        input  pkt_data, pkt_valid, busy, err_header, err_short,
               err_overrun, err_checksum, pkt_count, err_count
    );

    modport slave (
        input  cs_n, sck, sdi, pkt_ready,
        output pkt_data, pkt_valid, busy, err_header, err_short,
               err_overrun, err_checksum, pkt_count, err_count
    );
endinterface
`default_nettype wire

// File: rtl/spi_packet_rx.sv
`default_nettype none
// ============================================================================
// Module  : spi_packet_rx
// Brief   : SPI slave packet receiver with header check and valid/ready
//           output; `define SPI_RX_CHECKSUM_EN enables the XOR checksum byte.
// Rev     : 1.0
// ============================================================================
module spi_packet_rx #(
    parameter int         PACKET_BYTES = 16,
    parameter logic [7:0] HEADER_BYTE  = 8'hAA,
    parameter int         SPI_MODE     = 0
) (
    input  wire            clk,
    input  wire            rst_n,
    spi_packet_rx_if.slave bus
);

    localparam int                 c_W           = 8 * PACKET_BYTES;
    localparam int                 c_IDX_W       = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX    = c_IDX_W'(PACKET_BYTES - 1);
    localparam bit                 c_SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_BODY    = 3'd2,
        S_WAIT_CS = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]         r_cs_sync;
    logic [1:0]         r_sck_sync;
    logic [1:0]         r_sdi_sync;
    logic               r_cs_d;
    logic               r_sck_d;
    logic [1:0]         r_init;
    logic               r_armed;

    logic [6:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [c_IDX_W-1:0] r_byte_idx;
    logic               r_got_bit;
    logic [c_W-1:0]     r_stage;

    logic [c_W-1:0]     r_pkt_data;
    logic               r_pkt_valid;
    logic [15:0]        r_pkt_count;
    logic [7:0]         r_err_count;
    logic               r_err_header;
    logic               r_err_short;
    logic               r_err_overrun;

    logic               w_cs;
    logic               w_sck;
    logic               w_sdi;
    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_sample;
    logic               w_rx_state;
    logic               w_shift_en;
    logic [7:0]         w_byte;
    logic               w_byte_done;
    logic               w_commit;
    logic               w_err_header;
    logic               w_err_short;
    logic               w_err_overrun;
    logic [2:0]         w_err_num;
    logic [8:0]         w_err_sum;

`ifdef SPI_RX_CHECKSUM_EN
    logic [7:0]         r_csum;
    logic               r_csum_ok;
    logic               r_err_checksum;
    logic               w_err_checksum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync  <= 2'b11;
            r_sck_sync <= 2'b00;
            r_sdi_sync <= 2'b00;
            r_cs_d     <= 1'b1;
            r_sck_d    <= 1'b0;
            r_init     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[0], bus.cs_n};
            r_sck_sync <= {r_sck_sync[0], bus.sck};
            r_sdi_sync <= {r_sdi_sync[0], bus.sdi};
            r_cs_d     <= w_cs;
            r_sck_d    <= w_sck;
            r_init     <= {r_init[0], 1'b1};
            // Arm only once cs_n has been seen high on real (post-reset) samples,
            // so a select already active at reset release is ignored.
            if (r_init[1] && w_cs) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_cs        = r_cs_sync[1];
    assign w_sck       = r_sck_sync[1];
    assign w_sdi       = r_sdi_sync[1];
    assign w_cs_fall   = r_armed & r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;
    assign w_sample    = c_SAMPLE_RISE ? (w_sck & ~r_sck_d) : (~w_sck & r_sck_d);
    assign w_rx_state  = (r_state == S_HDR) || (r_state == S_BODY);
    assign w_shift_en  = w_sample && w_rx_state && !w_cs_rise;
    assign w_byte      = {r_shift, w_sdi};
    assign w_byte_done = w_shift_en && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_commit      = 1'b0;
        w_err_header  = 1'b0;
        w_err_short   = 1'b0;
        w_err_overrun = 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
        w_err_checksum = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_err_short = r_got_bit;
                end else if (w_byte_done) begin
                    if (w_byte == HEADER_BYTE) begin
                        w_state_nxt = S_BODY;
                    end else begin
                        w_state_nxt  = S_DISCARD;
                        w_err_header = 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_err_short = r_got_bit;
                end else if (w_byte_done && (r_byte_idx == c_LAST_IDX)) begin
                    w_state_nxt = S_WAIT_CS;
                end
            end
            S_WAIT_CS: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
`ifdef SPI_RX_CHECKSUM_EN
                    if (!r_csum_ok) begin
                        w_err_checksum = 1'b1;
                    end else
`endif
                    if (!r_pkt_valid || bus.pkt_ready) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err_overrun = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_got_bit  <= 1'b0;
            r_stage    <= '0;
        end else if (w_cs_fall) begin
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_got_bit  <= 1'b0;
        end else if (w_shift_en) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_got_bit <= 1'b1;
            if (r_bit_cnt == 3'd7) begin
                for (int b = 0; b < PACKET_BYTES; b++) begin
                    if (r_byte_idx == c_IDX_W'(b)) begin
                        r_stage[c_W-8-8*b +: 8] <= w_byte;
                    end
                end
                r_byte_idx <= r_byte_idx + c_IDX_W'(1);
            end
        end
    end

`ifdef SPI_RX_CHECKSUM_EN
    // Running XOR of bytes 0..N-2; the verdict is latched when the last byte lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum    <= '0;
            r_csum_ok <= 1'b0;
        end else if (w_cs_fall) begin
            r_csum    <= '0;
            r_csum_ok <= 1'b0;
        end else if (w_byte_done) begin
            if (r_byte_idx == c_LAST_IDX) begin
                r_csum_ok <= (w_byte == r_csum);
            end else begin
                r_csum <= r_csum ^ w_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_checksum <= 1'b0;
        end else begin
            r_err_checksum <= w_err_checksum;
        end
    end

    assign bus.err_checksum = r_err_checksum;
    assign w_err_num = {2'b00, w_err_header} + {2'b00, w_err_short}
                     + {2'b00, w_err_overrun} + {2'b00, w_err_checksum};
`else
    assign bus.err_checksum = 1'b0;
    assign w_err_num = {2'b00, w_err_header} + {2'b00, w_err_short}
                     + {2'b00, w_err_overrun};
`endif

    assign w_err_sum = {1'b0, r_err_count} + {6'b000000, w_err_num};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_data    <= '0;
            r_pkt_valid   <= 1'b0;
            r_pkt_count   <= '0;
            r_err_count   <= '0;
            r_err_header  <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_header  <= w_err_header;
            r_err_short   <= w_err_short;
            r_err_overrun <= w_err_overrun;
            r_err_count   <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            // A commit in the handshake cycle keeps valid high with the new data.
            r_pkt_valid   <= w_commit | (r_pkt_valid & ~bus.pkt_ready);
            if (w_commit) begin
                r_pkt_data  <= r_stage;
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign bus.pkt_data    = r_pkt_data;
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.pkt_count   = r_pkt_count;
    assign bus.err_count   = r_err_count;
    assign bus.err_header  = r_err_header;
    assign bus.err_short   = r_err_short;
    assign bus.err_overrun = r_err_overrun;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
